// File: rtl/id_counter_if.sv
// Strobe/clock bundle between the DPLL loop filter, the ID counter and its consumers.
interface id_counter_if #(
    parameter int PEND_W = 4
);
    logic                     enable;
    logic                     carry;
    logic                     borrow;
    logic                     idOut;
    logic                     advPulse;
    logic                     retPulse;
    logic signed [PEND_W-1:0] pending;

    modport master (
        output enable, carry, borrow,
        input  idOut, advPulse, retPulse, pending
    );

    modport slave (
        input  enable, carry, borrow,
        output idOut, advPulse, retPulse, pending
    );
endinterface

// File: rtl/id_counter.sv
// Increment/decrement stage of the DPLL: turns loop-filter carry/borrow edges into
// one-cycle phase advances/retards of the divided recovered clock idOut.
module id_counter #(
    parameter int NOM_HALF = 4,
    parameter int PEND_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    id_counter_if.slave bus
);
    localparam int CW = $clog2(NOM_HALF + 2);
    localparam int SW = PEND_W + 2;

    // Last count index of each half-period flavour (length - 1).
    localparam logic [CW-1:0] LAST_ADV = CW'(NOM_HALF - 2);
    localparam logic [CW-1:0] LAST_NOM = CW'(NOM_HALF - 1);
    localparam logic [CW-1:0] LAST_RET = CW'(NOM_HALF);

    // Symmetric saturation: the most-negative code is never used.
    localparam logic signed [SW-1:0] SMAX = SW'((2 ** (PEND_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX;

    typedef enum logic [1:0] {
        NOMINAL = 2'd0,
        ADV     = 2'd1,
        RET     = 2'd2
    } adj_t;

    adj_t                     adj, adj_nxt;
    logic [CW-1:0]            halfCnt, lastIdx;
    logic                     carryQ, borrowQ;
    logic                     cE, bE;
    logic                     boundary;
    logic                     consumeDec, consumeInc;
    logic signed [PEND_W-1:0] pend, pend_nxt;
    logic signed [SW-1:0]     sum;
    logic                     idOutR, advR, retR;

    assign cE = bus.carry & ~carryQ;
    assign bE = bus.borrow & ~borrowQ;

    // Half-period terminal count selected by the adjustment latched at the last boundary.
    always_comb begin
        lastIdx = LAST_NOM;
        case (adj)
            ADV:     lastIdx = LAST_ADV;
            RET:     lastIdx = LAST_RET;
            default: lastIdx = LAST_NOM;
        endcase
    end

    assign boundary = bus.enable && (halfCnt == lastIdx);

    // Next adjustment and pending-correction consumption, decided on the pre-update pending value.
    always_comb begin
        adj_nxt    = adj;
        consumeDec = 1'b0;
        consumeInc = 1'b0;
        if (boundary) begin
            if (!pend[PEND_W-1] && (pend != '0)) begin
                adj_nxt    = ADV;
                consumeDec = 1'b1;
            end else if (pend[PEND_W-1]) begin
                adj_nxt    = RET;
                consumeInc = 1'b1;
            end else begin
                adj_nxt = NOMINAL;
            end
        end
    end

    // Saturating accumulation of requests minus consumed corrections.
    always_comb begin
        sum = {{2{pend[PEND_W-1]}}, pend};
        if (cE && !bE)
            sum = sum + SW'(1);
        else if (bE && !cE)
            sum = sum - SW'(1);
        if (consumeDec)
            sum = sum - SW'(1);
        if (consumeInc)
            sum = sum + SW'(1);
        pend_nxt = sum[PEND_W-1:0];
        if (sum > SMAX)
            pend_nxt = SMAX[PEND_W-1:0];
        else if (sum < SMIN)
            pend_nxt = SMIN[PEND_W-1:0];
    end

    // Edge-detect history and pending accumulator run regardless of enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carryQ  <= 1'b0;
            borrowQ <= 1'b0;
            pend    <= '0;
        end else begin
            carryQ  <= bus.carry;
            borrowQ <= bus.borrow;
            pend    <= pend_nxt;
        end
    end

    // Half-period counter, recovered clock and end-of-corrected-half strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halfCnt <= '0;
            idOutR  <= 1'b0;
            adj     <= NOMINAL;
            advR    <= 1'b0;
            retR    <= 1'b0;
        end else begin
            advR <= boundary && (adj == ADV);
            retR <= boundary && (adj == RET);
            adj  <= adj_nxt;
            if (boundary) begin
                halfCnt <= '0;
                idOutR  <= ~idOutR;
            end else if (bus.enable) begin
                halfCnt <= halfCnt + 1'b1;
            end
        end
    end

    assign bus.idOut    = idOutR;
    assign bus.advPulse = advR;
    assign bus.retPulse = retR;
    assign bus.pending  = pend;
endmodule
